// File: rtl/audio_dac_serializer.sv
// I2S transmitter for the WM8731 DAC: buffers stereo pairs from an Avalon-ST sink
// and shifts them out on DACDAT, slaved to the codec-supplied BCLK and DACLRCK.
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2*DATA_WIDTH-1:0]       sink_data,
  input  logic                          sink_valid,
  output logic                          sink_ready,
  input  logic                          dac_bclk,
  input  logic                          dac_lrck,
  output logic                          dac_dat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  input  logic                          underflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] WORD_BITS  = CW'(DATA_WIDTH);

  localparam logic [1:0] ALIGN = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;

  logic [2:0]              r_bclkSync;
  logic [1:0]              r_lrckSync;
  logic                    r_lrckS;
  logic                    r_active;

  logic [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wrPtr;
  logic [AW-1:0]           r_rdPtr;
  logic [AW:0]             r_level;

  logic [1:0]              r_state;
  logic [DATA_WIDTH-1:0]   r_shreg;
  logic [DATA_WIDTH-1:0]   r_hold;
  logic [CW-1:0]           r_cnt;
  logic                    r_dacDat;
  logic                    r_underflow;

  logic                    w_fallEvt;
  logic                    w_lrckNow;
  logic                    w_lrckFall;
  logic                    w_lrckRise;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_leftLoad;
  logic                    w_pop;
  logic [2*DATA_WIDTH-1:0] w_popData;

  // BCLK gets a third stage for edge detection; LRCK stops at two so both
  // arrive with the same latency and are seen together on a fall event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bclkSync <= '0;
      r_lrckSync <= '0;
    end else begin
      r_bclkSync <= {r_bclkSync[1:0], dac_bclk};
      r_lrckSync <= {r_lrckSync[0], dac_lrck};
    end
  end

  assign w_fallEvt  = r_bclkSync[2] & ~r_bclkSync[1];
  assign w_lrckNow  = r_lrckSync[1];
  assign w_lrckFall = w_fallEvt & r_lrckS & ~w_lrckNow;
  assign w_lrckRise = w_fallEvt & ~r_lrckS & w_lrckNow;

  assign w_full     = (r_level == FULL_LEVEL);
  assign w_empty    = (r_level == '0);
  assign sink_ready = r_active & ~w_full;
  assign w_push     = sink_valid & sink_ready;
  assign w_leftLoad = (r_state != LEFT) & w_lrckFall;
  assign w_pop      = w_leftLoad & ~w_empty;
  assign w_popData  = r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= sink_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_level  <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Every load emits the I2S one-bit delay slot before the MSB; a word cut
  // short by an early LRCK toggle simply loses its remaining LSBs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ALIGN;
      r_shreg     <= '0;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_dacDat    <= 1'b0;
      r_lrckS     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (underflow_clr) begin
        r_underflow <= 1'b0;
      end
      if (w_fallEvt) begin
        r_lrckS <= w_lrckNow;
        if (w_leftLoad) begin
          r_state  <= LEFT;
          r_dacDat <= 1'b0;
          r_cnt    <= WORD_BITS;
          if (!w_empty) begin
            r_shreg <= w_popData[2*DATA_WIDTH-1:DATA_WIDTH];
            r_hold  <= w_popData[DATA_WIDTH-1:0];
          end else begin
            r_shreg     <= '0;
            r_hold      <= '0;
            r_underflow <= 1'b1;
          end
        end else if ((r_state == LEFT) && w_lrckRise) begin
          r_state  <= RIGHT;
          r_dacDat <= 1'b0;
          r_cnt    <= WORD_BITS;
          r_shreg  <= r_hold;
        end else if (r_state == ALIGN) begin
          r_dacDat <= 1'b0;
        end else if (r_cnt != '0) begin
          r_dacDat <= r_shreg[DATA_WIDTH-1];
          r_shreg  <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
          r_cnt    <= r_cnt - 1'b1;
        end else begin
          r_dacDat <= 1'b0;
        end
      end
    end
  end

  assign dac_dat    = r_dacDat;
  assign fifo_level = r_level;
  assign underflow  = r_underflow;

endmodule
